game_menu_ctl: RTL and testbench

GAME_MENU_CTL -- requirements
Module: game_menu_ctl

---
 rtl/game_menu_ctl_if.sv | 27 ++
 rtl/game_menu_ctl.sv | 154 +++++++++++++++
 tb/tb_game_menu_ctl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_menu_ctl_if.sv
// Signal bundle between the game menu controller and its surroundings:
// timing/key/game inputs toward the controller, menu state back out.
interface game_menu_ctl_if;
  logic       vblnk;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_enter;
  logic       game_over;
  logic       is_game_on;
  logic       sel_item;
  logic [3:0] size_val;
  logic [3:0] lvl_val;
  logic [1:0] state;
  logic [7:0] frame_cnt;

  modport master (
    output vblnk, key_up, key_down, key_left, key_right, key_enter, game_over,
    input  is_game_on, sel_item, size_val, lvl_val, state, frame_cnt
  );

  modport slave (
    input  vblnk, key_up, key_down, key_left, key_right, key_enter, game_over,
    output is_game_on, sel_item, size_val, lvl_val, state, frame_cnt
  );
endinterface

// File: rtl/game_menu_ctl.sv
// Menu / countdown / play / game-over controller. Key presses are captured as
// edge flags and acted on once per frame, at the rising edge of vblnk.
module game_menu_ctl #(
  parameter int SIZE_MIN     = 1,
  parameter int SIZE_MAX     = 9,
  parameter int LVL_MIN      = 1,
  parameter int LVL_MAX      = 9,
  parameter int START_FRAMES = 60,
  parameter int OVER_FRAMES  = 120
) (
  input  logic          clk,
  input  logic          rst,
  game_menu_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    MENU      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } state_t;

  localparam logic [3:0] SIZE_LO    = 4'(SIZE_MIN);
  localparam logic [3:0] SIZE_HI    = 4'(SIZE_MAX);
  localparam logic [3:0] LVL_LO     = 4'(LVL_MIN);
  localparam logic [3:0] LVL_HI     = 4'(LVL_MAX);
  localparam logic [7:0] START_LOAD = 8'(START_FRAMES - 1);
  localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES - 1);

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_ENTER = 4;

  function automatic logic [3:0] inc_sat(input logic [3:0] v, input logic [3:0] hi);
    return (v >= hi) ? hi : v + 4'd1;
  endfunction

  function automatic logic [3:0] dec_sat(input logic [3:0] v, input logic [3:0] lo);
    return (v <= lo) ? lo : v - 4'd1;
  endfunction

  logic [4:0] key_p0;
  logic [4:0] key_p1;
  logic [4:0] key_pend;
  logic [4:0] key_ev;
  logic       vblnk_p1;
  logic       tick;

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic [3:0] size_q, size_d;
  logic [3:0] lvl_q, lvl_d;
  logic [7:0] fc_q, fc_d;
  logic       on_q;

  assign key_p0 = {bus.key_enter, bus.key_right, bus.key_left, bus.key_down, bus.key_up};
  assign key_ev = key_pend | (key_p0 & ~key_p1);
  assign tick   = bus.vblnk & ~vblnk_p1;

  // Stage p1: registered key/vblnk copies and pending-event flags.
  // The copies track their inputs even in reset, so a key held across reset
  // release looks already-pressed and must be released before it counts.
  always_ff @(posedge clk) begin
    key_p1   <= key_p0;
    vblnk_p1 <= bus.vblnk;
    if (rst) begin
      key_pend <= '0;
    end else begin
      key_pend <= tick ? 5'd0 : key_ev;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    size_d  = size_q;
    lvl_d   = lvl_q;
    fc_d    = fc_q;
    if (tick) begin
      case (state_q)
        MENU: begin
          if (key_ev[K_UP] ^ key_ev[K_DOWN]) sel_d = ~sel_q;
          if (key_ev[K_RIGHT] && !key_ev[K_LEFT]) begin
            if (sel_q) lvl_d = inc_sat(lvl_q, LVL_HI);
            else       size_d = inc_sat(size_q, SIZE_HI);
          end else if (key_ev[K_LEFT] && !key_ev[K_RIGHT]) begin
            if (sel_q) lvl_d = dec_sat(lvl_q, LVL_LO);
            else       size_d = dec_sat(size_q, SIZE_LO);
          end
          if (key_ev[K_ENTER]) begin
            state_d = COUNTDOWN;
            fc_d    = START_LOAD;
          end
        end
        COUNTDOWN: begin
          if (key_ev[K_ENTER]) begin
            state_d = MENU;
            fc_d    = 8'd0;
          end else if (fc_q == 8'd0) begin
            state_d = PLAY;
          end else begin
            fc_d = fc_q - 8'd1;
          end
        end
        PLAY: begin
          if (bus.game_over) begin
            state_d = OVER;
            fc_d    = OVER_LOAD;
          end
        end
        OVER: begin
          if (key_ev[K_ENTER] || fc_q == 8'd0) begin
            state_d = MENU;
            sel_d   = 1'b0;
            fc_d    = 8'd0;
          end else begin
            fc_d = fc_q - 8'd1;
          end
        end
        default: state_d = MENU;
      endcase
    end
  end

  // Stage p1: committed menu state; is_game_on is decoded from the next state
  // so it lines up with state without an extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MENU;
      sel_q   <= 1'b0;
      size_q  <= SIZE_LO;
      lvl_q   <= LVL_LO;
      fc_q    <= 8'd0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      size_q  <= size_d;
      lvl_q   <= lvl_d;
      fc_q    <= fc_d;
      on_q    <= (state_d == PLAY);
    end
  end

  assign bus.is_game_on = on_q;
  assign bus.sel_item   = sel_q;
  assign bus.size_val   = size_q;
  assign bus.lvl_val    = lvl_q;
  assign bus.state      = state_q;
  assign bus.frame_cnt  = fc_q;

endmodule

// File: tb/tb_game_menu_ctl.sv
// Scoreboard bench for game_menu_ctl: each frame tick pushes the expected
// menu snapshot, which is popped and compared once the DUT has updated.
module tb_game_menu_ctl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  game_menu_ctl_if bus();

  game_menu_ctl #(
    .SIZE_MIN(1), .SIZE_MAX(9), .LVL_MIN(1), .LVL_MAX(9),
    .START_FRAMES(3), .OVER_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [4:0] UP    = 5'b00001;
  localparam logic [4:0] DOWN  = 5'b00010;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] RIGHT = 5'b01000;
  localparam logic [4:0] ENTER = 5'b10000;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  string       tag_q[$];
  logic        vblnk_prev = 1'b0;
  logic        tick_flag  = 1'b0;

  logic       e_on;
  logic [1:0] e_state;
  logic       e_sel;
  logic [3:0] e_size;
  logic [3:0] e_lvl;
  logic [7:0] e_fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] pack(input logic on, input logic [1:0] st, input logic sel,
                                       input logic [3:0] sz, input logic [3:0] lv,
                                       input logic [7:0] fc);
    return {on, st, sel, sz, lv, fc};
  endfunction

  always @(posedge clk) begin
    tick_flag  <= bus.vblnk & ~vblnk_prev & ~rst;
    vblnk_prev <= bus.vblnk;
  end

  always @(negedge clk) begin
    if (tick_flag) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check(tag_q.pop_front(),
              32'(pack(bus.is_game_on, bus.state, bus.sel_item, bus.size_val,
                       bus.lvl_val, bus.frame_cnt)),
              32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [4:0] m);
    {bus.key_enter, bus.key_right, bus.key_left, bus.key_down, bus.key_up} = m;
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    set_keys(m);
    cyc(2);
    set_keys(5'd0);
    cyc(2);
  endtask

  task automatic frame(input string tag);
    exp_q.push_back(pack(e_on, e_state, e_sel, e_size, e_lvl, e_fc));
    tag_q.push_back(tag);
    @(negedge clk);
    bus.vblnk = 1'b1;
    cyc(2);
    bus.vblnk = 1'b0;
    cyc(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.vblnk     = 1'b0;
    bus.game_over = 1'b0;
    set_keys(5'd0);
    bus.key_right = 1'b1;
    cyc(3);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_on",    32'(bus.is_game_on), 32'd0);
    check("rst_sel",   32'(bus.sel_item), 32'd0);
    check("rst_size",  32'(bus.size_val), 32'd1);
    check("rst_lvl",   32'(bus.lvl_val), 32'd1);
    check("rst_fc",    32'(bus.frame_cnt), 32'd0);
    rst = 1'b0;
    {e_on, e_state, e_sel, e_size, e_lvl, e_fc} = {1'b0, 2'd0, 1'b0, 4'd1, 4'd1, 8'd0};

    // Right held through reset release must not register.
    frame("held_key_no_event");
    bus.key_right = 1'b0;
    cyc(2);

    press(LEFT);
    frame("size_min_sat");

    for (int i = 0; i < 3; i++) begin
      press(RIGHT);
      e_size = e_size + 4'd1;
      frame("size_inc");
    end

    press(DOWN);
    e_sel = 1'b1;
    frame("sel_down");

    for (int i = 0; i < 12; i++) begin
      press(RIGHT);
      if (e_lvl < 4'd9) e_lvl = e_lvl + 4'd1;
      frame("lvl_inc_sat");
    end
    for (int i = 0; i < 12; i++) begin
      press(LEFT);
      if (e_lvl > 4'd1) e_lvl = e_lvl - 4'd1;
      frame("lvl_dec_sat");
    end

    press(DOWN);
    e_sel = 1'b0;
    frame("sel_back");

    // Two right pulses and up+down within one frame.
    press(RIGHT);
    press(RIGHT);
    press(UP | DOWN);
    e_size = 4'd5;
    frame("multi_pulse_frame");

    press(LEFT | RIGHT);
    frame("lr_cancel");

    press(ENTER);
    e_state = 2'd1; e_fc = 8'd2;
    frame("cd_load");
    e_fc = 8'd1;
    frame("cd_dec1");
    e_fc = 8'd0;
    frame("cd_dec0");
    e_state = 2'd2; e_on = 1'b1;
    frame("play_entry");

    press(RIGHT);
    frame("play_frozen");
    bus.game_over = 1'b1;
    e_state = 2'd3; e_fc = 8'd1; e_on = 1'b0;
    frame("over_load");
    bus.game_over = 1'b0;
    e_fc = 8'd0;
    frame("over_dec");
    e_state = 2'd0;
    frame("over_to_menu");

    press(ENTER);
    e_state = 2'd1; e_fc = 8'd2;
    frame("cd_load2");
    press(ENTER);
    e_state = 2'd0; e_fc = 8'd0;
    frame("cd_abort");

    press(DOWN);
    e_sel = 1'b1;
    frame("sel_before_game");
    press(ENTER);
    e_state = 2'd1; e_fc = 8'd2;
    frame("cd_load3");
    e_fc = 8'd1;
    frame("cd3_dec1");
    e_fc = 8'd0;
    frame("cd3_dec0");
    e_state = 2'd2; e_on = 1'b1;
    frame("play_entry2");
    bus.game_over = 1'b1;
    e_state = 2'd3; e_fc = 8'd1; e_on = 1'b0;
    frame("over_load2");
    bus.game_over = 1'b0;
    press(ENTER);
    e_state = 2'd0; e_fc = 8'd0; e_sel = 1'b0;
    frame("over_enter_exit");

    press(ENTER);
    e_state = 2'd1; e_fc = 8'd2;
    frame("cd_load4");
    e_fc = 8'd1;
    frame("cd4_dec1");

    // Reset in the middle of the countdown.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_fc",    32'(bus.frame_cnt), 32'd0);
    check("mid_rst_size",  32'(bus.size_val), 32'd1);
    check("mid_rst_lvl",   32'(bus.lvl_val), 32'd1);
    check("mid_rst_on",    32'(bus.is_game_on), 32'd0);
    check("mid_rst_sel",   32'(bus.sel_item), 32'd0);
    rst = 1'b0;

    cyc(4);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
